// File: rtl/edge_event_arbiter_pkg.sv
// Shared definitions for the dual-edge event arbiter: default channel count,
// index-width helper, polarity encoding and output-stage states.
package edge_event_arbiter_pkg;

    localparam int DEFAULT_N = 4;

    localparam logic RISE = 1'b1;
    localparam logic FALL = 1'b0;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event port carrying the granted channel index and edge polarity.
interface edge_event_arbiter_if
    import edge_event_arbiter_pkg::*;
#(
    parameter int N = DEFAULT_N
) ();
    localparam int IDX_W = clog2(N);

    logic             ev_valid;
    logic             ev_ready;
    logic [IDX_W-1:0] ev_chan;
    logic             ev_rise;

    modport master (output ev_valid, output ev_chan, output ev_rise, input ev_ready);
    modport slave  (input ev_valid, input ev_chan, input ev_rise, output ev_ready);
endinterface

// File: rtl/edge_event_arbiter_chan.sv
// One channel: edge detector, single-entry pending event (flag + polarity)
// and sticky overrun flag for edges that arrive while an event is still queued.
module edge_event_chan
    import edge_event_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    input  logic grant,
    input  logic clr_overrun,
    output logic pend,
    output logic pol,
    output logic overrun
);
    logic level_q;
    logic toggle;
    logic drop;

    assign toggle = level ^ level_q;
    // A granted channel frees its slot this cycle, so a coincident edge refills it.
    assign drop   = toggle & pend & ~grant;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
            pend    <= 1'b0;
            pol     <= FALL;
            overrun <= 1'b0;
        end else begin
            level_q <= level;
            if (grant) begin
                pend <= toggle;
                if (toggle) pol <= level ? RISE : FALL;
            end else if (toggle && !pend) begin
                pend <= 1'b1;
                pol  <= level ? RISE : FALL;
            end
            if (drop) overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end
endmodule

// File: rtl/edge_event_arbiter.sv
// Dual-edge event scheduler: per-channel pending events serialised onto one
// registered valid/ready port by a round-robin search starting at rr_ptr.
module edge_event_arbiter
    import edge_event_arbiter_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         level,
    edge_event_arbiter_if.master ev,
    output logic [N-1:0]         overrun,
    input  logic                 clr_overrun
);
    localparam int IDX_W = clog2(N);

    logic [N-1:0]     pend;
    logic [N-1:0]     pol;
    logic [N-1:0]     grant;
    logic             found;
    logic             load;
    logic [IDX_W-1:0] gidx;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_next;
    logic [IDX_W-1:0] chan_q;
    logic             rise_q;
    out_state_e       state_q;
    out_state_e       state_d;

    for (genvar i = 0; i < N; i++) begin : g_chan
        edge_event_chan u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .level       (level[i]),
            .grant       (grant[i]),
            .clr_overrun (clr_overrun),
            .pend        (pend[i]),
            .pol         (pol[i]),
            .overrun     (overrun[i])
        );
    end

    always_comb begin
        int unsigned cand;
        found = 1'b0;
        gidx  = '0;
        cand  = 0;
        for (int unsigned j = 0; j < N; j++) begin
            cand = (32'(rr_ptr) + j) % N;
            if (!found && pend[cand]) begin
                found = 1'b1;
                gidx  = IDX_W'(cand);
            end
        end
    end

    assign load    = (state_q == EMPTY) | ev.ev_ready;
    assign grant   = (load && found) ? (N'(1) << gidx) : '0;
    assign rr_next = (gidx == IDX_W'(N - 1)) ? '0 : gidx + 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (found) state_d = FULL;
            FULL:    if (ev.ev_ready) state_d = found ? FULL : EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            rr_ptr  <= '0;
            chan_q  <= '0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load && found) begin
                chan_q <= gidx;
                rise_q <= pol[gidx];
                rr_ptr <= rr_next;
            end
        end
    end

    assign ev.ev_valid = (state_q == FULL);
    assign ev.ev_chan  = chan_q;
    assign ev.ev_rise  = rise_q;
endmodule
